// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder split into STAGES carry-chained chunks with valid/ready flow control
// Optional overflow port: define PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
    end

    logic             r_v [STAGES];
    logic             r_c [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];

    // Index k of the *_src arrays is what feeds stage k; index STAGES is the output.
    logic             w_v_src [STAGES+1];
    logic             w_c_src [STAGES+1];
    logic [WIDTH-1:0] w_a_src [STAGES+1];
    logic [WIDTH-1:0] w_b_src [STAGES+1];
    logic [WIDTH-1:0] w_s_src [STAGES+1];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_nxt [STAGES];
    logic [CW:0]      w_chunk;
    logic             w_en;
    logic             w_unused;

    always_comb begin
        w_v_src[0] = in_valid;
        w_c_src[0] = cin;
        w_a_src[0] = a;
        w_b_src[0] = b;
        w_s_src[0] = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_v_src[k+1] = r_v[k];
            w_c_src[k+1] = r_c[k];
            w_a_src[k+1] = r_a[k];
            w_b_src[k+1] = r_b[k];
            w_s_src[k+1] = r_s[k];
        end
        w_chunk = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_chunk = {1'b0, w_a_src[k][k*CW +: CW]}
                    + {1'b0, w_b_src[k][k*CW +: CW]}
                    + (CW+1)'(w_c_src[k]);
            w_s_nxt[k] = w_s_src[k];
            w_s_nxt[k][k*CW +: CW] = w_chunk[CW-1:0];
            w_c_nxt[k] = w_chunk[CW];
        end
        // Operand bits already consumed by earlier chunks are intentionally dropped.
        w_unused = 1'b0;
        for (int k = 0; k <= STAGES; k++) begin
            w_unused = w_unused ^ (^w_a_src[k]) ^ (^w_b_src[k]);
        end
    end

    assign w_en      = !w_v_src[STAGES] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = w_v_src[STAGES];
    assign sum       = w_s_src[STAGES];
    assign carry_out = w_c_src[STAGES];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    assign overflow = (w_a_src[STAGES][WIDTH-1] == w_b_src[STAGES][WIDTH-1])
                   && (w_s_src[STAGES][WIDTH-1] != w_a_src[STAGES][WIDTH-1]);
`endif

    // Data registers are cleared too so outputs read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_c[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k] <= w_v_src[k];
                r_c[k] <= w_c_nxt[k];
                r_a[k] <= w_a_src[k];
                r_b[k] <= w_b_src[k];
                r_s[k] <= w_s_nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - Self-checking bench for pipelined_adder (8/2, 1/1 and 16/4 configurations)
`timescale 1ns/1ps
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       iv8, ir8, ci8, ov8, or8, co8;
    logic [7:0] a8, b8, s8;
    logic       iv1, ir1, ci1, ov1, or1, co1;
    logic [0:0] a1, b1, s1;
    logic        iv16, ir16, ci16, ov16, or16, co16;
    logic [15:0] a16, b16, s16;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic of8, of1, of16;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .carry_out(co8)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(of8)
`endif
    );

    pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .carry_out(co1)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(of1)
`endif
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(ci16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .carry_out(co16)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        , .overflow(of16)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [16:0] q8[$];
    logic [32:0] q16[$];

    function automatic logic ref_ovf(input int w, input longint ua, input longint ub, input longint uc);
        longint half, sa, sb, t;
        half = longint'(1) << (w - 1);
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        t  = sa + sb + uc;
        return (t >= half) || (t < -half);
    endfunction

    // One 8-bit cycle: entered and left at posedge+1; scoreboard updated on each handshake.
    task automatic cycle8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c, input logic r);
        logic [16:0] e;
        logic [8:0]  full;
        iv8 = v; a8 = a; b8 = b; ci8 = c; or8 = r;
        #1;
        if (ov8 && r) begin
            n_checks++;
            if (q8.size() == 0) begin
                $display("FAIL d8_extra_output: got sum=%h carry=%b, required no output", s8, co8);
            end else begin
                e = q8.pop_front();
                full = 9'(e[15:8]) + 9'(e[7:0]) + 9'(e[16]);
                if ({co8, s8} !== full)
                    $display("FAIL d8_result: got %h, required %h", {co8, s8}, full);
                else
                    n_pass++;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                n_checks++;
                if (of8 !== ref_ovf(8, longint'(e[15:8]), longint'(e[7:0]), longint'(e[16])))
                    $display("FAIL d8_overflow: got %b, required %b", of8,
                             ref_ovf(8, longint'(e[15:8]), longint'(e[7:0]), longint'(e[16])));
                else
                    n_pass++;
`endif
            end
        end
        if (v && ir8) q8.push_back({c, a, b});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({ov8, ir8, co8, s8} !== {1'b0, 1'b1, 1'b0, 8'h00})
            $display("FAIL reset_d8: got v=%b rdy=%b c=%b s=%h, required 0 1 0 00", ov8, ir8, co8, s8);
        else n_pass++;
        n_checks++;
        if ({ov1, ir1, co1, s1} !== 4'b0100)
            $display("FAIL reset_d1: got %b, required 0100", {ov1, ir1, co1, s1});
        else n_pass++;
        n_checks++;
        if ({ov16, ir16, co16, s16} !== {1'b0, 1'b1, 1'b0, 16'h0000})
            $display("FAIL reset_d16: got v=%b rdy=%b c=%b s=%h, required 0 1 0 0000", ov16, ir16, co16, s16);
        else n_pass++;
    endtask

    task automatic test_carry;
        cycle8(1'b1, 8'hFF, 8'h01, 1'b0, 1'b1);
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL carry_early: got out_valid=%b, required 0", ov8);
        else n_pass++;
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'h00})
            $display("FAIL carry_result: got v=%b c=%b s=%h, required 1 1 00", ov8, co8, s8);
        else n_pass++;
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [3] = '{8'h10, 8'h7F, 8'h80};
        logic [7:0] vb [3] = '{8'h20, 8'h01, 8'h80};
        logic       vc [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] es [3] = '{8'h30, 8'h81, 8'h00};
        logic       ec [3] = '{1'b0, 1'b0, 1'b1};
        logic       eo [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            if (i >= 2) begin
                n_checks++;
                if ({ov8, co8, s8} !== {1'b1, ec[i-2], es[i-2]})
                    $display("FAIL b2b_out%0d: got v=%b c=%b s=%h, required 1 %b %h", i - 2, ov8, co8, s8, ec[i-2], es[i-2]);
                else n_pass++;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                n_checks++;
                if (of8 !== eo[i-2]) $display("FAIL b2b_ovf%0d: got %b, required %b", i - 2, of8, eo[i-2]);
                else n_pass++;
`else
                if (eo[i-2] === 1'bx) $display("b2b: unexpected table entry");
`endif
            end
            if (i < 3) cycle8(1'b1, va[i], vb[i], vc[i], 1'b1);
            else       cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        end
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL b2b_tail: got out_valid=%b, required 0", ov8);
        else n_pass++;
    endtask

    task automatic test_stall;
        logic [7:0] hs;
        logic       hc;
        cycle8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        cycle8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        hs = s8; hc = co8;
        for (int j = 0; j < 3; j++) begin
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom); or8 = 1'b0;
            #1;
            n_checks++;
            if (ir8 !== 1'b0) $display("FAIL stall_in_ready%0d: got %b, required 0", j, ir8);
            else n_pass++;
            n_checks++;
            if ({ov8, co8, s8} !== {1'b1, hc, hs})
                $display("FAIL stall_hold%0d: got v=%b c=%b s=%h, required 1 %b %h", j, ov8, co8, s8, hc, hs);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        for (int j = 0; j < 4; j++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (q8.size() != 0) $display("FAIL stall_lost: got %0d results outstanding, required 0", q8.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        cycle8(1'b1, 8'h11, 8'h22, 1'b0, 1'b1);
        cycle8(1'b1, 8'h33, 8'h44, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ov8, ir8, co8, s8} !== {1'b0, 1'b1, 1'b0, 8'h00})
            $display("FAIL midreset_flush: got v=%b rdy=%b c=%b s=%h, required 0 1 0 00", ov8, ir8, co8, s8);
        else n_pass++;
        q8.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle8(1'b1, 8'hA5, 8'h3C, 1'b1, 1'b1);
        n_checks++;
        if (ov8 !== 1'b0) $display("FAIL midreset_early: got out_valid=%b, required 0", ov8);
        else n_pass++;
        cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if ({ov8, co8, s8} !== {1'b1, 1'b0, 8'hE2})
            $display("FAIL midreset_new: got v=%b c=%b s=%h, required 1 0 e2", ov8, co8, s8);
        else n_pass++;
        for (int j = 0; j < 3; j++) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        n_checks++;
        if (q8.size() != 0) $display("FAIL midreset_drain: got %0d outstanding, required 0", q8.size());
        else n_pass++;
    endtask

    task automatic test_full_adder;
        logic [2:0] combo;
        logic [1:0] full;
        or1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            a1 = combo[2]; b1 = combo[1]; ci1 = combo[0]; iv1 = 1'b1;
            @(posedge clk);
            #1;
            iv1 = 1'b0;
            full = 2'(combo[2]) + 2'(combo[1]) + 2'(combo[0]);
            n_checks++;
            if ({ov1, co1, s1} !== {1'b1, full})
                $display("FAIL full_adder_%0d: got v=%b c=%b s=%b, required 1 %b", i, ov1, co1, s1, full);
            else n_pass++;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
            n_checks++;
            if (of1 !== ref_ovf(1, longint'(combo[2]), longint'(combo[1]), longint'(combo[0])))
                $display("FAIL full_adder_ovf_%0d: got %b", i, of1);
            else n_pass++;
`endif
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (ov1 !== 1'b0) $display("FAIL full_adder_tail: got out_valid=%b, required 0", ov1);
        else n_pass++;
    endtask

    task automatic test_random16;
        int acc = 0;
        int cyc = 0;
        logic v, r;
        logic [32:0] e;
        logic [16:0] full;
        while (cyc < 40000 && (acc < 10000 || q16.size() != 0)) begin
            v = (acc < 10000) && ($urandom_range(0, 3) != 0);
            r = (acc >= 10000) || ($urandom_range(0, 3) != 0);
            iv16 = v; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); or16 = r;
            #1;
            if (ov16 && r) begin
                n_checks++;
                if (q16.size() == 0) begin
                    $display("FAIL d16_extra_output: got sum=%h, required no output", s16);
                end else begin
                    e = q16.pop_front();
                    full = 17'(e[31:16]) + 17'(e[15:0]) + 17'(e[32]);
                    if ({co16, s16} !== full) $display("FAIL d16_result: got %h, required %h", {co16, s16}, full);
                    else n_pass++;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
                    n_checks++;
                    if (of16 !== ref_ovf(16, longint'(e[31:16]), longint'(e[15:0]), longint'(e[32])))
                        $display("FAIL d16_overflow: got %b", of16);
                    else n_pass++;
`endif
                end
            end
            if (v && ir16) begin
                q16.push_back({ci16, a16, b16});
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        iv16 = 1'b0;
        n_checks++;
        if (acc != 10000 || q16.size() != 0)
            $display("FAIL d16_budget: got accepted=%0d outstanding=%0d, required 10000 and 0", acc, q16.size());
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; or8 = 0;
        iv1 = 0; a1 = 0; b1 = 0; ci1 = 0; or1 = 0;
        iv16 = 0; a16 = 0; b16 = 0; ci16 = 0; or16 = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        test_carry;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        test_full_adder;
        test_random16;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; SHALL be >= 1.
REQ-002 Parameter STAGES, default 2, number of register stages; SHALL satisfy 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0.
REQ-003 Port clk, input, 1 bit; the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit; operands a, b and cin are valid this cycle.
REQ-006 Port in_ready, output, 1 bit; block accepts an operand set this cycle.
REQ-007 Port a, input, WIDTH bits; unsigned operand A.
REQ-008 Port b, input, WIDTH bits; unsigned operand B.
REQ-009 Port cin, input, 1 bit; carry in.
REQ-010 Port out_valid, output, 1 bit; sum, carry_out and overflow are valid.
REQ-011 Port out_ready, input, 1 bit; downstream accepts the result this cycle.
REQ-012 Port sum, output, WIDTH bits; low WIDTH bits of a+b+cin.
REQ-013 Port carry_out, output, 1 bit; bit WIDTH of a+b+cin.
REQ-014 Port overflow, output, 1 bit; present only per REQ-031.

Function
REQ-015 The block SHALL split the addition into STAGES chunks of CW = WIDTH/STAGES bits; stage k adds bits [k*CW +: CW] of a and b plus the registered carry from stage k-1 (stage 0 uses cin).
REQ-016 Operand bits not yet consumed and sum bits already produced SHALL be carried forward in delay registers so each result leaves with its own operands, in order.
REQ-017 Every stage SHALL hold one valid bit; the result SHALL equal the full-precision a+b+cin, with {carry_out,sum} = (a+b+cin) mod 2^(WIDTH+1).
REQ-018 Transfer rule: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-019 Pipeline advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational, no dependence on in_valid).
REQ-020 When en = 1 all stages SHALL shift one position; stage 0 valid loads in_valid.
REQ-021 When en = 0 all stage registers, including valid bits, SHALL hold; sum, carry_out and overflow SHALL stay stable while out_valid && !out_ready.
REQ-022 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready is held high.
REQ-023 Throughput SHALL be one result per cycle when in_valid and out_ready are both held high; no bubbles.
REQ-024 Bubbles (in_valid = 0 while en = 1) SHALL propagate as invalid slots and SHALL not stall younger data behind them in later cycles.
REQ-025 Simultaneous output consume and input accept in the same cycle SHALL lose and duplicate no data.
REQ-026 With WIDTH = 1 and STAGES = 1, behaviour SHALL equal a one-bit adder registered once: sum = a^b^cin, carry_out = majority(a,b,cin).
REQ-027 Data registers need not be reset; only valid bits are control state.

Reset
REQ-028 While rst_n = 0, all stage valid bits SHALL be 0, out_valid = 0 and in_ready = 1.
REQ-029 Assertion mid-operation SHALL discard all in-flight results immediately, with no partial output; sum, carry_out and overflow SHALL read 0 during reset.
REQ-030 After rst_n deasserts, the first accepted input SHALL appear after exactly STAGES cycles.

Configuration
REQ-031 Macro PIPELINED_ADDER_OVERFLOW_EN: when defined, port overflow exists and SHALL equal two's-complement signed overflow of a+b+cin (a[W-1]==b[W-1] && sum[W-1]!=a[W-1]), aligned and valid with sum; when undefined, the port and its logic SHALL be absent and all other behaviour is identical.

Verification
REQ-032 WIDTH=8, STAGES=2, a=0xFF, b=0x01, cin=0, out_ready=1 -> two cycles later out_valid=1, sum=0x00, carry_out=1.
REQ-033 WIDTH=8, STAGES=2, back-to-back inputs (0x10,0x20,0), (0x7F,0x01,1), (0x80,0x80,0) -> outputs on consecutive cycles 0x30/0, 0x81/0, 0x00/1; with the macro defined, overflow = 0, 1, 1.
REQ-034 out_ready=0 for 3 cycles while the pipeline is full -> in_ready=0, outputs held constant; release -> results delivered in order, none lost or duplicated.
REQ-035 rst_n pulsed low with 2 results in flight -> out_valid=0 at once; after release only newly accepted data appears.
REQ-036 WIDTH=1, STAGES=1, all 8 combinations of a,b,cin -> sum/carry_out match a full-adder truth table one cycle after acceptance.
REQ-037 WIDTH=16, STAGES=4, 10,000 random operands with random in_valid and out_ready -> every result equals the reference a+b+cin, in order.
